// File: rtl/skew_pkg.sv
// Shared types and constants for the skewed double-buffered tile store.
package skew_pkg;

  localparam int unsigned DefDim  = 8;
  localparam int unsigned DefBits = 8;

  typedef enum logic {IDLE, DRAIN} state_e;

  typedef logic signed [DefBits*DefDim-1:0] row_t;
  typedef logic [$clog2(DefDim)-1:0]        idx_t;

  // Beats 0..2*DIM-2 must fit in the counter.
  localparam int unsigned BeatW = $clog2(2*DefDim-1);

  function automatic int unsigned beat_w(input int unsigned dim);
    return $clog2(2*dim-1);
  endfunction

endpackage

// File: rtl/skew_bank.sv
// One DIM x DIM operand bank with row-written mask and a skewed combinational read.
module skew_bank
  import skew_pkg::*;
#(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8,
  parameter int unsigned TW      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(DIM)-1:0]      wr_row,
  input  logic signed [BITS_AB*DIM-1:0] wr_data,
  input  logic                        clr,
  input  logic [TW-1:0]               rd_t,
  input  logic                        rd_mode,
  output logic signed [BITS_AB*DIM-1:0] lanes
);

  localparam int unsigned IW = $clog2(DIM);

  logic [BITS_AB-1:0] mem_q [DIM][DIM];
  logic [DIM-1:0]     mask_q;

  // Data is not reset; the mask alone decides whether a row reads as zero.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int c = 0; c < int'(DIM); c++) begin
        mem_q[wr_row][c] <= wr_data[c*BITS_AB +: BITS_AB];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
    end else if (clr) begin
      mask_q <= '0;
    end else if (wr_en) begin
      mask_q[wr_row] <= 1'b1;
    end
  end

  always_comb begin
    int k;
    logic [IW-1:0] ix;
    logic [IW-1:0] kx;
    lanes = '0;
    k     = 0;
    ix    = '0;
    kx    = '0;
    for (int i = 0; i < int'(DIM); i++) begin
      k  = int'(rd_t) - i;
      ix = IW'(i);
      kx = IW'(k);
      if (k >= 0 && k < int'(DIM)) begin
        if (!rd_mode) begin
          if (mask_q[ix]) lanes[i*BITS_AB +: BITS_AB] = mem_q[ix][kx];
        end else begin
          if (mask_q[kx]) lanes[i*BITS_AB +: BITS_AB] = mem_q[kx][ix];
        end
      end
    end
  end

endmodule

// File: rtl/skew_tile_buffer.sv
// Ping-pong tile store draining committed tiles as a diagonally skewed lane stream.
module skew_tile_buffer
  import skew_pkg::*;
#(
  parameter int unsigned BITS_AB = 8,
  parameter int unsigned DIM     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [$clog2(DIM)-1:0]        wr_row,
  input  logic signed [BITS_AB*DIM-1:0] wr_data,
  input  logic                          wr_commit,
  output logic                          wr_ready,
  input  logic                          start,
  input  logic                          transpose,
  output logic signed [BITS_AB*DIM-1:0] out_data,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned TW = beat_w(DIM);
  localparam logic [TW-1:0] LastT = TW'(2*DIM-2);

  state_e state_q, state_d;
  logic          wb_q, rb_q;
  logic [1:0]    full_cnt_q;
  logic [TW-1:0] t_q;
  logic          mode_q;
  logic signed [BITS_AB*DIM-1:0] out_q;
  logic          valid_q, done_q;

  logic          wr_ok, commit_ok, start_ok, drain_end;
  logic [TW-1:0] rd_t;
  logic          rd_mode;
  logic signed [BITS_AB*DIM-1:0] lanes0, lanes1, rd_lanes;

  assign wr_ready  = (full_cnt_q < 2'd2);
  assign wr_ok     = wr_en & wr_ready;
  assign commit_ok = wr_commit & wr_ready;
  assign start_ok  = (state_q == IDLE) && start && (full_cnt_q != 2'd0);
  assign drain_end = (state_q == DRAIN) && (t_q == LastT);

  // On the accepting edge beat 0 is fetched with the freshly sampled mode.
  assign rd_t     = start_ok ? '0 : t_q + 1'b1;
  assign rd_mode  = start_ok ? transpose : mode_q;
  assign rd_lanes = rb_q ? lanes1 : lanes0;

  skew_bank #(.BITS_AB(BITS_AB), .DIM(DIM), .TW(TW)) u_bank0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok && !wb_q),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .clr     (drain_end && !rb_q),
    .rd_t    (rd_t),
    .rd_mode (rd_mode),
    .lanes   (lanes0)
  );

  skew_bank #(.BITS_AB(BITS_AB), .DIM(DIM), .TW(TW)) u_bank1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok && wb_q),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .clr     (drain_end && rb_q),
    .rd_t    (rd_t),
    .rd_mode (rd_mode),
    .lanes   (lanes1)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = DRAIN;
      DRAIN:   if (drain_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wb_q       <= 1'b0;
      rb_q       <= 1'b0;
      full_cnt_q <= 2'd0;
      t_q        <= '0;
      mode_q     <= 1'b0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (commit_ok) wb_q <= ~wb_q;
      if (drain_end) rb_q <= ~rb_q;
      case ({commit_ok, drain_end})
        2'b10:   full_cnt_q <= full_cnt_q + 2'd1;
        2'b01:   full_cnt_q <= full_cnt_q - 2'd1;
        default: full_cnt_q <= full_cnt_q;
      endcase
      if (start_ok) begin
        t_q     <= '0;
        mode_q  <= transpose;
        out_q   <= rd_lanes;
        valid_q <= 1'b1;
        done_q  <= 1'b0;
      end else if (state_q == DRAIN) begin
        if (drain_end) begin
          out_q   <= '0;
          valid_q <= 1'b0;
          done_q  <= 1'b0;
        end else begin
          t_q    <= rd_t;
          out_q  <= rd_lanes;
          done_q <= (rd_t == LastT);
        end
      end
    end
  end

  assign out_data  = out_q;
  assign out_valid = valid_q;
  assign busy      = (state_q == DRAIN);
  assign done      = done_q;

endmodule

// File: doc/skew_tile_buffer.md
# skew_tile_buffer

Double-buffered operand tile store for the systolic MAC array. It holds up to two DIM×DIM tiles of signed BITS_AB operands, written one row per cycle. Each committed tile drains as a diagonally skewed stream, one element per lane per cycle, directly into the array edge. It generalises the single-tile transpose buffer with three additions:
- selectable transpose/pass-through mode
- ping-pong banks, so the next tile loads while the current one drains
- an explicit ready/start/done handshake

## Interface
Parameters:
- BITS_AB, 8, operand width (signed)
- DIM, 8, tile dimension and lane count; power of two, ≥2

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- wr_en  in  1  write wr_data into row wr_row of the current write bank
- wr_row  in  $clog2(DIM)  target row index
- wr_data  in  BITS_AB×DIM signed  row elements; element c is column c
- wr_commit  in  1  close the current write bank and mark it FULL
- wr_ready  out  1  a non-full write bank exists
- start  in  1  begin draining the oldest FULL bank
- transpose  in  1  drain mode, sampled when start is accepted
- out_data  out  BITS_AB×DIM signed  skewed lane outputs
- out_valid  out  1  out_data is a drain beat
- busy  out  1  drain in progress
- done  out  1  one-cycle pulse on the final drain beat

## Operation
- **Banks:** two banks, each DIM×DIM elements plus a DIM-bit row-written mask. Each bank is FREE (writable) or FULL. A bank stays FULL while it drains.
- **Pointers:** write pointer wb and read pointer rb, both 1 bit. full_cnt ranges 0..2. wr_ready = (full_cnt < 2).
- **Write:** on wr_en && wr_ready, bank[wb].row[wr_row] <= wr_data and mask[wr_row] <= 1. Writes while wr_ready=0 are dropped. Rewriting a row overwrites it.
- **Commit:** on wr_commit && wr_ready, bank wb becomes FULL and wb toggles. A write in the same cycle lands in the committing bank. Committing an empty bank is legal and yields an all-zero tile.
- **FSM:** two states, IDLE and DRAIN.
  - IDLE → DRAIN on start when full_cnt ≥ 1, judged on the pre-edge value. On that edge, latch the transpose mode and clear t.
  - start is ignored in DRAIN, and ignored when full_cnt = 0. This includes a start in the same cycle as the first commit.
  - DRAIN → IDLE after beat t = 2·DIM−2. On that edge bank rb becomes FREE (mask cleared), rb toggles, and full_cnt decrements. A simultaneous commit nets full_cnt unchanged.
- **Lane value at beat t, lane i, with k = t−i:**
  - normal mode: A[i][k]
  - transpose mode: A[k][i]
  - zero when k<0 or k≥DIM, or when the addressed row's mask bit is 0.
- **Arithmetic:** no arithmetic is performed; values pass bit-exact, sign preserved.
- **Reset:** out_data=0, out_valid=0, busy=0, done=0, wr_ready=1, all banks FREE, all masks 0, wb=rb=0, state IDLE.
  - Reset mid-drain or mid-fill discards all contents.

## Timing
- Start accepted at edge e: out_valid, busy and out_data are registered and high for the 2·DIM−1 cycles following e. Beat t appears in cycle e+1+t.
- done coincides with the last out_valid cycle. busy falls the cycle after done.
- The earliest next start is accepted at the edge that ends the done cycle's successor. That gives one idle cycle minimum between tiles.
- wr_ready is combinational from full_cnt. A bank freed at the end of a drain is writable in the next cycle.
- Latency from commit to the earliest beat 0 is 2 cycles: commit edge, start edge, then the output register.

## Structure
- Package skew_pkg:
  - state enum {IDLE, DRAIN}
  - typedefs row_t (signed BITS_AB×DIM) and idx_t ($clog2(DIM))
  - beat-counter width constant for 2·DIM−1
- Sub-module skew_bank, instantiated twice:
  - DIM×DIM storage with row mask and write port
  - clear input
  - combinational skewed read of all lanes given t and mode
- The top level holds the pointers, full_cnt, the FSM, the output register and the bank select mux.

## Test plan
All scenarios use DIM=8, BITS_AB=8, and A[r][c] = 10·r + c unless stated.
- **Normal drain:** write rows 0..7, commit, start with transpose=0. Beat 0 = {0,0,…}. Beat 3 lanes 0..3 = 3, 12, 21, 30. Beat 14 lane 7 = 77. done in the 15th valid cycle.
- **Transpose drain:** same tile, transpose=1. Beat 3 lanes 0..3 = 30, 21, 12, 3. Beat 14 lane 7 = 77.
- **Ping-pong and backpressure:**
  - Commit tile A, start, then load and commit tile B (all 50s) during the drain. wr_ready=0 until A's done cycle completes.
  - A third commit in that window is dropped.
  - B then drains all 50s in its non-zero diagonal.
- **Partial tile and negatives:** write only row 2 = {−128, −1, 0, 127, …}, commit, drain normal. Lane 2 shows −128, −1, 0, 127 at beats 2..5. Every other lane is zero on all beats.
- **Ignored starts:**
  - A start with no FULL bank gives no out_valid.
  - A start during a drain neither extends the drain nor restarts it.
  - A commit on the final drain beat leaves full_cnt at 1.
- **Reset:** assert rst at beat 6 of a drain. Next cycle: out_valid=0, busy=0, wr_ready=1. A following start gives no output.
